mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Round-robin arbiter that shares the single scalar MemoryBus between NUM_REQ requesters, e.g. the vector memory controller and per-core fetch/load-store units.
- Accepts one request at a time and forwards it to memory.
- For reads, waits for the memory response and routes it back to the granted requester only.
- Writes complete once memory accepts them; no response is returned.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 64, address width
DATA_W, 64, data/payload width
SRC_W, 8, source (core/thread id) tag width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request pending; held until matching req_ready
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_source  in  NUM_REQ*SRC_W  packed source tags
req_ready  out  NUM_REQ  one-hot one-cycle accept pulse
resp_valid  out  NUM_REQ  one-hot read response valid
resp_data  out  DATA_W  read payload, valid with resp_valid
resp_ready  in  NUM_REQ  requester consumes response
mem_req_valid  out  1  request to memory
mem_req_write  out  1  request type
mem_req_addr  out  ADDR_W  request address
mem_req_wdata  out  DATA_W  request write data
mem_req_source  out  SRC_W  request source tag
mem_req_ready  in  1  memory accepts (inverse of request_busy)
mem_resp_valid  in  1  memory read response present
mem_resp_data  in  DATA_W  memory read payload
protocol_err  out  1  sticky: mem_resp_valid seen outside WAIT_RESP

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0. protocol_err=0. Any in-flight transaction is abandoned.
- All outputs are registered. Only state-held values drive the memory and requester sides.
- IDLE:
  - If any req_valid is set, pick winner w = first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - At that edge: latch write/addr/wdata/source of w, pulse req_ready[w] for exactly the next cycle, set mem_req_valid=1, go ISSUE.
  - If no req_valid is set, stay in IDLE.
- ISSUE:
  - Hold mem_req_* stable while mem_req_ready=0.
  - When mem_req_valid and mem_req_ready are both 1 at an edge, drop mem_req_valid and set last_grant=w.
  - Write: go IDLE. Read: go WAIT_RESP.
  - req_valid is ignored in this state. The requester may drop or change its request after req_ready.
- WAIT_RESP:
  - On mem_resp_valid=1, capture mem_resp_data into resp_data, set resp_valid[w]=1, go RETURN.
  - mem_resp_valid arriving in the same cycle as the ISSUE handshake is a protocol error: it is not captured and protocol_err is set.
- RETURN:
  - Hold resp_valid[w] and resp_data until resp_ready[w]=1 at an edge.
  - Then clear resp_valid and go IDLE.
  - resp_ready on any other index is ignored.
- Turnaround: a new grant can be issued in the cycle after returning to IDLE.
- Minimum read occupancy is 4 cycles: IDLE→ISSUE→WAIT_RESP→RETURN→IDLE. Minimum write occupancy is 2 cycles.
- Fairness:
  - A continuously requesting requester waits at most NUM_REQ-1 transactions before it is granted.
  - last_grant updates only on a completed memory handshake.
- protocol_err:
  - Set on mem_resp_valid=1 in IDLE, ISSUE or RETURN.
  - Cleared only by reset. The stray response is discarded and the state is unchanged.
- Only one transaction is outstanding at a time. No pipelining and no reordering.

Test Plan:
- Reset release, req_valid=2'b01, read addr=0x100, source=3, memory ready immediately, response 0xDEAD after 2 cycles → req_ready[0] pulse at cycle 1, mem_req_addr=0x100/source=3, resp_valid[0]=1 with resp_data=0xDEAD, resp_valid[1] never set.
- req_valid=2'b11 held continuously, all reads, 4 transactions → grant order 0,1,0,1; each req_ready is a single-cycle one-hot pulse.
- Write from requester 1 (addr=0x40, wdata=0x55) with mem_req_ready low for 5 cycles → mem_req_* stable for all 5 cycles, handshake on cycle 6, return to IDLE with no resp_valid.
- Read response held while resp_ready[0]=0 for 3 cycles → resp_valid[0] and resp_data stay stable; requester 1 is not granted until resp_ready[0] is asserted and the arbiter returns to IDLE.
- mem_resp_valid pulse while IDLE → protocol_err=1 and stays 1; a following normal read still completes correctly.
- reset_n asserted during WAIT_RESP → all outputs 0 immediately (async); after release with req_valid=2'b11, requester 0 is granted first.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the memory port.
// The slave modport is the arbiter's view; master is the environment driving requests and memory.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*SRC_W-1:0]  req_source;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_data;
    logic [NUM_REQ-1:0]        resp_ready;
    logic                      mem_req_valid;
    logic                      mem_req_write;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic [DATA_W-1:0]         mem_req_wdata;
    logic [SRC_W-1:0]          mem_req_source;
    logic                      mem_req_ready;
    logic                      mem_resp_valid;
    logic [DATA_W-1:0]         mem_resp_data;
    logic                      protocol_err;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_source, resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_data,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_source,
        output protocol_err
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_source, resp_ready,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_data,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_source,
        input  protocol_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one scalar memory port between NUM_REQ requesters,
// one transaction outstanding at a time.
//
// state     | meaning
// IDLE      | no transaction; grant next requester round-robin
// ISSUE     | request presented to memory, waiting for mem_req_ready
// WAIT_RESP | read accepted, waiting for mem_resp_valid
// RETURN    | read data held for the granted requester until resp_ready
module mem_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int SRC_W   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    mem_bus_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RETURN} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [NUM_REQ-1:0] resp_valid_q;
    logic [DATA_W-1:0]  resp_data_q;
    logic               mem_valid_q;
    logic               mem_write_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [SRC_W-1:0]   mem_source_q;
    logic               protocol_err_q;

    logic [IDX_W-1:0]   pick;
    logic               pick_found;
    logic [CNT_W-1:0]   cand;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [SRC_W-1:0]   sel_source;

    // Scan upward from the requester after last_grant, wrapping at NUM_REQ.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + CNT_W'(k);
            if (cand >= CNT_W'(NUM_REQ)) begin
                cand = cand - CNT_W'(NUM_REQ);
            end
            if (!pick_found && bus.req_valid[cand[IDX_W-1:0]]) begin
                pick       = cand[IDX_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_write  = 1'b0;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_source = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_write  = bus.req_write[i];
                sel_addr   = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata  = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_source = bus.req_source[i*SRC_W +: SRC_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            last_grant     <= IDX_W'(NUM_REQ - 1);
            grant          <= '0;
            req_ready_q    <= '0;
            resp_valid_q   <= '0;
            resp_data_q    <= '0;
            mem_valid_q    <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_source_q   <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            req_ready_q <= '0;
            case (state)
                IDLE: begin
                    if (bus.mem_resp_valid) begin
                        protocol_err_q <= 1'b1;
                    end
                    if (pick_found) begin
                        grant        <= pick;
                        mem_write_q  <= sel_write;
                        mem_addr_q   <= sel_addr;
                        mem_wdata_q  <= sel_wdata;
                        mem_source_q <= sel_source;
                        mem_valid_q  <= 1'b1;
                        req_ready_q  <= NUM_REQ'(1) << pick;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A response during the handshake cycle cannot belong to this request.
                    if (bus.mem_resp_valid) begin
                        protocol_err_q <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        mem_valid_q <= 1'b0;
                        last_grant  <= grant;
                        state       <= mem_write_q ? IDLE : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_resp_valid) begin
                        resp_data_q  <= bus.mem_resp_data;
                        resp_valid_q <= NUM_REQ'(1) << grant;
                        state        <= RETURN;
                    end
                end
                RETURN: begin
                    if (bus.mem_resp_valid) begin
                        protocol_err_q <= 1'b1;
                    end
                    if (bus.resp_ready[grant]) begin
                        resp_valid_q <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_data      = resp_data_q;
    assign bus.mem_req_valid  = mem_valid_q;
    assign bus.mem_req_write  = mem_write_q;
    assign bus.mem_req_addr   = mem_addr_q;
    assign bus.mem_req_wdata  = mem_wdata_q;
    assign bus.mem_req_source = mem_source_q;
    assign bus.protocol_err   = protocol_err_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic
// checked against a round-robin transaction model.
module tb_mem_bus_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int SRC_W   = 8;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_last;

    logic               m_write  [NUM_REQ];
    logic [ADDR_W-1:0]  m_addr   [NUM_REQ];
    logic [DATA_W-1:0]  m_wdata  [NUM_REQ];
    logic [SRC_W-1:0]   m_source [NUM_REQ];

    mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) bus ();

    mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid      = '0;
        bus.req_write      = '0;
        bus.req_addr       = '0;
        bus.req_wdata      = '0;
        bus.req_source     = '0;
        bus.resp_ready     = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset_n  = 1'b1;
        exp_last = NUM_REQ - 1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [SRC_W-1:0] s);
        bus.req_write[i]                   = wr;
        bus.req_addr[i*ADDR_W +: ADDR_W]   = a;
        bus.req_wdata[i*DATA_W +: DATA_W]  = d;
        bus.req_source[i*SRC_W +: SRC_W]   = s;
        m_write[i]  = wr;
        m_addr[i]   = a;
        m_wdata[i]  = d;
        m_source[i] = s;
    endtask

    task automatic wait_grant(output logic [NUM_REQ-1:0] got, output bit ok);
        got = '0;
        ok  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.req_ready != '0) begin
                got = bus.req_ready;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    // Reference rule: first requesting index after the previous winner, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        bus.req_valid = '1;
        tick();
        tick();
        n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== '0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_req_addr); end
        n_checks++; if (bus.mem_req_source !== '0) begin n_fail++; $display("FAIL reset_mem_source: got %h want 0", bus.mem_req_source); end
        n_checks++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_protocol_err: got %b want 0", bus.protocol_err); end
        bus.req_valid = '0;
        reset_n  = 1'b1;
        exp_last = NUM_REQ - 1;
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 64'h100, '0, 8'd3);
        bus.req_valid     = 2'b01;
        bus.mem_req_ready = 1'b1;
        tick();
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_req_ready: got %b want 01", bus.req_ready); end
        n_checks++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rd_mem_valid: got %b want 1", bus.mem_req_valid); end
        n_checks++; if (bus.mem_req_addr !== 64'h100) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 100", bus.mem_req_addr); end
        n_checks++; if (bus.mem_req_source !== 8'd3) begin n_fail++; $display("FAIL rd_mem_source: got %h want 3", bus.mem_req_source); end
        n_checks++; if (bus.mem_req_write !== 1'b0) begin n_fail++; $display("FAIL rd_mem_write: got %b want 0", bus.mem_req_write); end
        bus.req_valid = '0;
        tick();
        exp_last = 0;
        n_checks++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== '0) begin
            n_fail++; $display("FAIL rd_after_hs: mem_valid %b req_ready %b want 0/00", bus.mem_req_valid, bus.req_ready);
        end
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hDEAD;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 2'b01) begin n_fail++; $display("FAIL rd_resp_valid: got %b want 01", bus.resp_valid); end
        n_checks++; if (bus.resp_data !== 64'hDEAD) begin n_fail++; $display("FAIL rd_resp_data: got %h want dead", bus.resp_data); end
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = '0;
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL rd_resp_clear: got %b want 00", bus.resp_valid); end
        n_checks++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("FAIL rd_protocol_err: got %b want 0", bus.protocol_err); end
    endtask

    task automatic test_round_robin();
        int order [4] = '{0, 1, 0, 1};
        logic [NUM_REQ-1:0] got;
        bit ok;
        apply_reset();
        set_req(0, 1'b0, 64'h1000, '0, 8'd10);
        set_req(1, 1'b0, 64'h2000, '0, 8'd11);
        bus.req_valid     = 2'b11;
        bus.mem_req_ready = 1'b1;
        bus.resp_ready    = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_grant(got, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_grant_timeout: txn %0d got none want grant", t); end
            n_checks++; if (got !== (NUM_REQ'(1) << order[t])) begin
                n_fail++; $display("FAIL rr_order: txn %0d got %b want %b", t, got, NUM_REQ'(1) << order[t]);
            end
            n_checks++; if (bus.mem_req_addr !== m_addr[order[t]]) begin
                n_fail++; $display("FAIL rr_addr: txn %0d got %h want %h", t, bus.mem_req_addr, m_addr[order[t]]);
            end
            tick();
            n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL rr_pulse_width: txn %0d got %b want 00", t, bus.req_ready); end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 64'hA000 + 64'(t);
            tick();
            bus.mem_resp_valid = 1'b0;
            n_checks++; if (bus.resp_valid !== (NUM_REQ'(1) << order[t]) || bus.resp_data !== 64'hA000 + 64'(t)) begin
                n_fail++; $display("FAIL rr_resp: txn %0d got %b/%h want %b/%h", t, bus.resp_valid, bus.resp_data,
                                   NUM_REQ'(1) << order[t], 64'hA000 + 64'(t));
            end
        end
        tick();
        bus.req_valid  = '0;
        bus.resp_ready = '0;
        tick();
        exp_last = 1;
    endtask

    task automatic test_write_stall();
        set_req(1, 1'b1, 64'h40, 64'h55, 8'd7);
        bus.req_valid     = 2'b10;
        bus.mem_req_ready = 1'b0;
        tick();
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL wr_req_ready: got %b want 10", bus.req_ready); end
        bus.req_valid = '0;
        for (int c = 1; c <= 5; c++) begin
            n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_write !== 1'b1 || bus.mem_req_addr !== 64'h40 ||
                            bus.mem_req_wdata !== 64'h55 || bus.mem_req_source !== 8'd7) begin
                n_fail++; $display("FAIL wr_stall_stable: cycle %0d got v%b w%b a%h d%h s%h want 1/1/40/55/07", c, bus.mem_req_valid,
                                   bus.mem_req_write, bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_source);
            end
            if (c > 1) begin
                n_checks++; if (bus.req_ready !== '0) begin n_fail++; $display("FAIL wr_req_ready_clear: cycle %0d got %b want 00", c, bus.req_ready); end
            end
            if (c < 5) tick();
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        exp_last = 1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wr_handshake: mem_valid got %b want 0", bus.mem_req_valid); end
        tick();
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL wr_no_resp: got %b want 00", bus.resp_valid); end
    endtask

    task automatic test_resp_hold();
        set_req(0, 1'b0, 64'h500, '0, 8'd1);
        set_req(1, 1'b1, 64'h80, 64'h77, 8'd2);
        bus.req_valid = 2'b01;
        tick();
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL hold_grant0: got %b want 01", bus.req_ready); end
        bus.req_valid     = 2'b10;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hCAFE_F00D;
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.resp_ready     = 2'b10;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'hCAFE_F00D || bus.req_ready !== '0) begin
                n_fail++; $display("FAIL hold_stable: cycle %0d got %b/%h/%b want 01/cafef00d/00", c, bus.resp_valid, bus.resp_data, bus.req_ready);
            end
            tick();
        end
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = '0;
        n_checks++; if (bus.resp_valid !== '0 || bus.req_ready !== '0) begin
            n_fail++; $display("FAIL hold_release: got %b/%b want 00/00", bus.resp_valid, bus.req_ready);
        end
        tick();
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL hold_grant1: got %b want 10", bus.req_ready); end
        bus.req_valid = '0;
        tick();
        exp_last = 1;
        n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_wr_done: got %b want 0", bus.mem_req_valid); end
    endtask

    task automatic test_protocol_err();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h1111;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", bus.protocol_err); end
        n_checks++; if (bus.resp_valid !== '0 || bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL perr_discard: got %b/%b want 00/0", bus.resp_valid, bus.mem_req_valid);
        end
        repeat (3) tick();
        n_checks++; if (bus.protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", bus.protocol_err); end
        set_req(1, 1'b0, 64'h300, '0, 8'd9);
        bus.req_valid = 2'b10;
        tick();
        n_checks++; if (bus.req_ready !== 2'b10 || bus.mem_req_addr !== 64'h300) begin
            n_fail++; $display("FAIL perr_read_grant: got %b/%h want 10/300", bus.req_ready, bus.mem_req_addr);
        end
        bus.req_valid = '0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hBEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 2'b10 || bus.resp_data !== 64'hBEEF) begin
            n_fail++; $display("FAIL perr_read_resp: got %b/%h want 10/beef", bus.resp_valid, bus.resp_data);
        end
        bus.resp_ready = 2'b10;
        tick();
        bus.resp_ready = '0;
        set_req(0, 1'b0, 64'h400, '0, 8'd4);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid      = '0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'hBAD;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL perr_hs_not_captured: got %b want 00", bus.resp_valid); end
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h1234;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'h1234) begin
            n_fail++; $display("FAIL perr_late_resp: got %b/%h want 01/1234", bus.resp_valid, bus.resp_data);
        end
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = '0;
        exp_last = 0;
    endtask

    task automatic test_async_reset();
        logic [NUM_REQ-1:0] got;
        bit ok;
        set_req(0, 1'b0, 64'h200, '0, 8'd1);
        bus.req_valid     = 2'b01;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.req_valid = '0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_req_addr !== '0 || bus.mem_req_source !== '0 || bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL areset_mem: got %h/%h/%b want 0", bus.mem_req_addr, bus.mem_req_source, bus.mem_req_valid);
        end
        n_checks++; if (bus.protocol_err !== 1'b0 || bus.resp_valid !== '0 || bus.resp_data !== '0 || bus.req_ready !== '0) begin
            n_fail++; $display("FAIL areset_out: got %b/%b/%h/%b want 0", bus.protocol_err, bus.resp_valid, bus.resp_data, bus.req_ready);
        end
        set_req(0, 1'b0, 64'h600, '0, 8'd5);
        set_req(1, 1'b0, 64'h700, '0, 8'd6);
        bus.req_valid = 2'b11;
        tick();
        tick();
        reset_n  = 1'b1;
        exp_last = NUM_REQ - 1;
        wait_grant(got, ok);
        n_checks++; if (!ok || got !== 2'b01) begin n_fail++; $display("FAIL areset_first_grant: got %b want 01", got); end
        bus.req_valid = '0;
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 64'h600D;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_checks++; if (bus.resp_valid !== 2'b01 || bus.resp_data !== 64'h600D) begin
            n_fail++; $display("FAIL areset_resp: got %b/%h want 01/600d", bus.resp_valid, bus.resp_data);
        end
        bus.resp_ready = 2'b01;
        tick();
        bus.resp_ready = '0;
        exp_last = 0;
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] mask;
        logic [NUM_REQ-1:0] got;
        logic [NUM_REQ-1:0] exp_oh;
        logic [DATA_W-1:0]  rdata;
        bit ok;
        int w;
        int stall;
        for (int n = 0; n < 80; n++) begin
            mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                set_req(i, 1'($urandom), {$urandom(), $urandom()}, {$urandom(), $urandom()}, SRC_W'($urandom));
            end
            w      = rr_pick(mask, exp_last);
            exp_oh = NUM_REQ'(1) << w;
            bus.req_valid     = mask;
            bus.mem_req_ready = 1'b0;
            wait_grant(got, ok);
            n_checks++; if (!ok || got !== exp_oh) begin n_fail++; $display("FAIL rnd_grant: txn %0d got %b want %b", n, got, exp_oh); end
            n_checks++; if (bus.mem_req_write !== m_write[w] || bus.mem_req_addr !== m_addr[w] ||
                            bus.mem_req_wdata !== m_wdata[w] || bus.mem_req_source !== m_source[w]) begin
                n_fail++; $display("FAIL rnd_req_fields: txn %0d got %b/%h/%h/%h want %b/%h/%h/%h", n, bus.mem_req_write, bus.mem_req_addr,
                                   bus.mem_req_wdata, bus.mem_req_source, m_write[w], m_addr[w], m_wdata[w], m_source[w]);
            end
            bus.req_valid = NUM_REQ'($urandom);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                tick();
                n_checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== m_addr[w] || bus.req_ready !== '0) begin
                    n_fail++; $display("FAIL rnd_stall: txn %0d got %b/%h/%b want 1/%h/00", n, bus.mem_req_valid, bus.mem_req_addr, bus.req_ready, m_addr[w]);
                end
            end
            bus.req_valid     = '0;
            bus.mem_req_ready = 1'b1;
            tick();
            bus.mem_req_ready = 1'b0;
            exp_last = w;
            n_checks++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_handshake: txn %0d got %b want 0", n, bus.mem_req_valid); end
            if (m_write[w]) begin
                n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL rnd_wr_resp: txn %0d got %b want 00", n, bus.resp_valid); end
            end else begin
                repeat ($urandom_range(0, 2)) tick();
                rdata = {$urandom(), $urandom()};
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = rdata;
                tick();
                bus.mem_resp_valid = 1'b0;
                bus.resp_ready     = NUM_REQ'($urandom) & ~exp_oh;
                repeat ($urandom_range(0, 2)) tick();
                n_checks++; if (bus.resp_valid !== exp_oh || bus.resp_data !== rdata) begin
                    n_fail++; $display("FAIL rnd_resp: txn %0d got %b/%h want %b/%h", n, bus.resp_valid, bus.resp_data, exp_oh, rdata);
                end
                bus.resp_ready = exp_oh;
                tick();
                bus.resp_ready = '0;
                n_checks++; if (bus.resp_valid !== '0) begin n_fail++; $display("FAIL rnd_resp_clear: txn %0d got %b want 00", n, bus.resp_valid); end
            end
        end
        n_checks++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("FAIL rnd_protocol_err: got %b want 0", bus.protocol_err); end
    endtask

    initial begin
        reset_n  = 1'b0;
        exp_last = NUM_REQ - 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stall();
        test_resp_hold();
        test_protocol_err();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
